// File: rtl/sort_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// sort_pkg : shared widths and FSM states for the sorter family
// Rev 1.0
// ------------------------------------------------------------------
package sort_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ELEM_WIDTH = 2;
  localparam int NUM_ELEM   = DATA_WIDTH / ELEM_WIDTH;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sort_order_chk.sv
`default_nettype none
// ------------------------------------------------------------------
// sort_order_chk : flags a packed word that is not non-increasing
// Rev 1.0
// ------------------------------------------------------------------
module sort_order_chk
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = sort_pkg::DATA_WIDTH,
  parameter int ELEM_WIDTH = sort_pkg::ELEM_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] word,
  output logic                  err
);

  localparam int c_num_elem = DATA_WIDTH / ELEM_WIDTH;

  logic [c_num_elem-2:0] w_rise;

  // Element 0 sits in the MSBs; any strictly rising neighbour pair is an error.
  for (genvar i = 0; i < c_num_elem - 1; i++) begin : g_pair
    assign w_rise[i] = word[DATA_WIDTH-1-i*ELEM_WIDTH -: ELEM_WIDTH]
                     < word[DATA_WIDTH-1-(i+1)*ELEM_WIDTH -: ELEM_WIDTH];
  end

  assign err = |w_rise;

endmodule
`default_nettype wire

// File: rtl/sort_unpack.sv
`default_nettype none
// ------------------------------------------------------------------
// sort_unpack : streams a packed sorted word out one element per beat
// Rev 1.0
// ------------------------------------------------------------------
module sort_unpack
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = sort_pkg::DATA_WIDTH,
  parameter int ELEM_WIDTH = sort_pkg::ELEM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sort_vld,
  input  logic [DATA_WIDTH-1:0] sort,
  output logic                  sort_rdy,
  output logic [ELEM_WIDTH-1:0] dat,
  output logic                  dat_vld,
  input  logic                  dat_rdy,
  output logic [1:0]            dat_idx,
  output logic                  dat_last,
  output logic                  order_err,
  output logic [7:0]            err_cnt
);

  localparam int         c_num_elem = DATA_WIDTH / ELEM_WIDTH;
  localparam logic [1:0] c_last_idx = 2'(c_num_elem - 1);

  state_e                r_state;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [ELEM_WIDTH-1:0] w_elem [c_num_elem];
  logic [1:0]            w_next_idx;
  logic                  w_accept;
  logic                  w_order_err;

  for (genvar i = 0; i < c_num_elem; i++) begin : g_elem
    assign w_elem[i] = r_hold[DATA_WIDTH-1-i*ELEM_WIDTH -: ELEM_WIDTH];
  end

  sort_order_chk #(
    .DATA_WIDTH (DATA_WIDTH),
    .ELEM_WIDTH (ELEM_WIDTH)
  ) u_order_chk (
    .word (sort),
    .err  (w_order_err)
  );

  // Ready in EMIT only as the final element leaves, so words chain without a bubble.
  assign sort_rdy   = (r_state == IDLE) || (dat_idx == c_last_idx && dat_rdy);
  assign w_accept   = sort_vld && sort_rdy;
  assign w_next_idx = dat_idx + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      dat       <= '0;
      dat_idx   <= '0;
      dat_vld   <= 1'b0;
      dat_last  <= 1'b0;
      order_err <= 1'b0;
      err_cnt   <= '0;
    end else if (w_accept) begin
      r_state   <= EMIT;
      r_hold    <= sort;
      dat       <= sort[DATA_WIDTH-1 -: ELEM_WIDTH];
      dat_idx   <= '0;
      dat_vld   <= 1'b1;
      dat_last  <= (c_last_idx == 2'd0);
      order_err <= w_order_err;
      if (w_order_err && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end else if (r_state == EMIT && dat_rdy) begin
      if (dat_idx == c_last_idx) begin
        r_state  <= IDLE;
        dat_vld  <= 1'b0;
        dat_last <= 1'b0;
      end else begin
        dat_idx  <= w_next_idx;
        dat      <= w_elem[w_next_idx];
        dat_last <= (w_next_idx == c_last_idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sort_unpack.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_sort_unpack : vector table plus scoreboard bench for sort_unpack
// Rev 1.0
// ------------------------------------------------------------------
module tb_sort_unpack;

  localparam int DW = 8;
  localparam int EW = 2;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          sort_vld = 1'b0;
  logic [DW-1:0] sort     = '0;
  logic          dat_rdy  = 1'b1;
  logic          sort_rdy;
  logic [EW-1:0] dat;
  logic          dat_vld;
  logic [1:0]    dat_idx;
  logic          dat_last;
  logic          order_err;
  logic [7:0]    err_cnt;

  sort_unpack #(.DATA_WIDTH(DW), .ELEM_WIDTH(EW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sort_vld  (sort_vld),
    .sort      (sort),
    .sort_rdy  (sort_rdy),
    .dat       (dat),
    .dat_vld   (dat_vld),
    .dat_rdy   (dat_rdy),
    .dat_idx   (dat_idx),
    .dat_last  (dat_last),
    .order_err (order_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [EW-1:0] dat;
    logic [1:0]    idx;
    logic          last;
    logic          err;
  } beat_t;

  typedef struct {
    logic [DW-1:0] word;
    logic          exp_err;
  } vec_t;

  beat_t         q[$];
  int            n_checks  = 0;
  int            n_fail    = 0;
  int            model_cnt = 0;
  logic [EW-1:0] last_dat  = '0;
  logic          drv_err   = 1'b0;
  logic          mon_en    = 1'b0;
  logic          rnd_rdy   = 1'b0;
  vec_t          vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_err(input logic [DW-1:0] w);
    return !(w[7:6] >= w[5:4] && w[5:4] >= w[3:2] && w[3:2] >= w[1:0]);
  endfunction

  // Scoreboard: compare presented beat, pop on handshake, push on acceptance.
  beat_t b;
  logic  exp_rdy;
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("dat_vld", 32'(dat_vld), 32'(q.size() != 0));
      if (q.size() != 0) begin
        b       = q[0];
        exp_rdy = (b.idx == 2'd3) && dat_rdy;
        chk("dat", 32'(dat), 32'(b.dat));
        chk("dat_idx", 32'(dat_idx), 32'(b.idx));
        chk("dat_last", 32'(dat_last), 32'(b.last));
        chk("order_err", 32'(order_err), 32'(b.err));
        if (dat_rdy) begin
          void'(q.pop_front());
          last_dat = b.dat;
        end
      end else begin
        exp_rdy = 1'b1;
        chk("idle_dat_hold", 32'(dat), 32'(last_dat));
        chk("idle_dat_last", 32'(dat_last), 32'd0);
      end
      chk("sort_rdy", 32'(sort_rdy), 32'(exp_rdy));
      chk("err_cnt", 32'(err_cnt), 32'(model_cnt));
      if (sort_vld && exp_rdy) begin
        for (int k = 0; k < 4; k++) begin
          b.dat  = sort[DW-1-EW*k -: EW];
          b.idx  = 2'(k);
          b.last = (k == 3);
          b.err  = drv_err;
          q.push_back(b);
        end
        if (drv_err && model_cnt < 255) model_cnt++;
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      dat_rdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [DW-1:0] w, input logic e);
    bit ok;
    ok       = 1'b0;
    sort     = w;
    drv_err  = e;
    sort_vld = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = sort_rdy;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: word %h never accepted", w);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = (q.size() == 0) && !dat_vld;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats outstanding", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_dat"}, 32'(dat), 32'd0);
    chk({tag, "_dat_idx"}, 32'(dat_idx), 32'd0);
    chk({tag, "_dat_vld"}, 32'(dat_vld), 32'd0);
    chk({tag, "_dat_last"}, 32'(dat_last), 32'd0);
    chk({tag, "_order_err"}, 32'(order_err), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'hE4, 1'b0};
    vecs[1] = '{8'h1B, 1'b1};
    vecs[2] = '{8'hAA, 1'b0};
    vecs[3] = '{8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b0};
    vecs[5] = '{8'h99, 1'b1};
    vecs[6] = '{8'hE0, 1'b0};
    vecs[7] = '{8'h6C, 1'b1};
    vecs[8] = '{8'hE5, 1'b0};
    vecs[9] = '{8'hF4, 1'b0};

    #2 rst_n = 1'b0;
    #1 check_reset_values("por");
    chk("por_sort_rdy", 32'(sort_rdy), 32'd1);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Table pass 0 with steady ready, pass 1 with random back-pressure.
    for (int pass = 0; pass < 2; pass++) begin
      rnd_rdy = (pass == 1);
      for (int i = 0; i < 10; i++) begin
        send(vecs[i].word, vecs[i].exp_err);
        sort_vld = 1'b0;
        drain();
      end
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #1;
    dat_rdy = 1'b1;
    drain();

    // Stall on beats 1 and 2 for three cycles each.
    send(8'hE4, 1'b0);
    sort_vld = 1'b0;
    @(posedge clk);
    #1;
    dat_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dat_rdy = 1'b1;
    @(posedge clk);
    #1;
    dat_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dat_rdy = 1'b1;
    drain();

    // Back-to-back words, no bubble expected.
    send(8'hE4, 1'b0);
    send(8'hAA, 1'b0);
    sort_vld = 1'b0;
    drain();

    // Asynchronous reset in the middle of a word.
    send(8'hE4, 1'b0);
    sort_vld = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1 check_reset_values("mid_rst");
    q.delete();
    model_cnt = 0;
    last_dat  = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(8'h1B, ref_err(8'h1B));
    sort_vld = 1'b0;
    drain();

    // Saturation of the error counter.
    for (int i = 0; i < 260; i++) begin
      send(8'h1B, ref_err(8'h1B));
    end
    sort_vld = 1'b0;
    drain();
    chk("err_cnt_saturated", 32'(err_cnt), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
